// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the fetch / IF-ID slice.
//   - RV32I major opcode constants used by immediate generation
//   - fetch FSM state type
//   - IF/ID register layout and its bubble (all-zero) value
package riscv_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // S_REQ : request outstanding at PC
  // S_HOLD: word received while stalled, kept in the side buffer
  // S_DROP: one stale response still in flight, discard it
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  // The raw word is kept whole; the field outputs are plain slices of it.
  typedef struct packed {
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '0;

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational RV32I immediate extraction.
//   instr : 32-bit instruction word
//   imm   : sign-extended immediate selected by the opcode (I/S/B/U/J),
//           zero for formats without an immediate
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  // NOTE: default first so every path through the case assigns imm (no latch).
  always_comb begin
    imm = '0;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR:
        imm = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {instr[31:12], 12'b0};
      OP_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: PC, instruction fetch handshake and IF/ID pipeline register.
//   clock, reset       : single clock, synchronous active-high reset
//   stall              : freezes PC and the IF/ID register
//   redirect_valid/_pc : taken branch/jump from EX (overrides stall)
//   imem_req/_addr     : fetch request at the current PC
//   imem_valid/_rdata  : fetch response
//   instr_valid, pc_out, opcode, rd, f3, rs1, rs2, f7, immediate : IF/ID fields
// Configuration macro IF_EARLY_JAL_EN: a JAL loaded into IF/ID redirects the
// PC to pc_out+immediate on the following cycle without flushing IF/ID.
module if_id_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  f3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  f7,
  output logic [31:0] immediate
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  hold_word;
  if_id_t       if_id, if_id_nxt;
  logic         reset_q;   // distinguishes the first reset cycle
  logic         load;      // a word enters IF/ID this cycle
  logic         buffer;    // response captured into hold_word
  logic [31:0]  load_word;
  logic [31:0]  load_imm;

  // Redirect sources: redir moves the PC, flush also bubbles IF/ID.
  logic        redir;
  logic [31:0] redir_pc;
  logic        flush;

`ifdef IF_EARLY_JAL_EN
  logic early_jal_q;  // one-shot: a JAL was loaded into IF/ID last edge

  assign redir    = redirect_valid | early_jal_q;
  assign redir_pc = redirect_valid ? redirect_pc : (if_id.pc + if_id.imm);
`else
  assign redir    = redirect_valid;
  assign redir_pc = redirect_pc;
`endif
  assign flush = redirect_valid;

  imm_gen u_imm_gen (
    .instr (load_word),
    .imm   (load_imm)
  );

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if_id_nxt = if_id;
    load      = 1'b0;
    buffer    = 1'b0;
    imem_req  = 1'b0;
    load_word = imem_rdata;

    case (state)
      S_REQ: begin
        imem_req = 1'b1;
        if (redir) begin
          // A response arriving now is the stale one; otherwise it is still
          // in flight and must be dropped when it shows up.
          state_nxt = imem_valid ? S_REQ : S_DROP;
        end else if (imem_valid) begin
          if (stall) begin
            buffer    = 1'b1;
            state_nxt = S_HOLD;
          end else begin
            load = 1'b1;
          end
        end
      end
      S_HOLD: begin
        load_word = hold_word;
        if (redir) begin
          state_nxt = S_REQ;   // buffered word discarded, nothing in flight
        end else if (!stall) begin
          load      = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_valid) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase

    if (redir)     pc_nxt = redir_pc;
    else if (load) pc_nxt = pc + PC_STEP;

    if (flush)       if_id_nxt = IF_ID_BUBBLE;
    else if (load)   if_id_nxt = '{instr_valid: 1'b1, pc: pc, instr: load_word, imm: load_imm};
    else if (!stall) if_id_nxt = IF_ID_BUBBLE;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      reset_q <= 1'b1;
      pc      <= RESET_PC;
      if_id   <= IF_ID_BUBBLE;
      // NOTE: the side buffer is cleared on reset so a discarded word can
      // never reappear after a restart.
      hold_word <= '0;
      // A request left unanswered when reset hits still has a response in
      // flight; drop it instead of treating it as the RESET_PC word.
      if (!reset_q && (state == S_REQ || state == S_DROP) && !imem_valid)
        state <= S_DROP;
      else
        state <= S_REQ;
    end else begin
      reset_q <= 1'b0;
      state   <= state_nxt;
      pc      <= pc_nxt;
      if_id   <= if_id_nxt;
      if (buffer) hold_word <= imem_rdata;
    end
  end

`ifdef IF_EARLY_JAL_EN
  always_ff @(posedge clock) begin
    if (reset) early_jal_q <= 1'b0;
    else       early_jal_q <= load && (load_word[6:0] == OP_JAL);
  end
`endif

  assign imem_addr   = pc;
  assign instr_valid = if_id.instr_valid;
  assign pc_out      = if_id.pc;
  assign opcode      = if_id.instr[6:0];
  assign rd          = if_id.instr[11:7];
  assign f3          = if_id.instr[14:12];
  assign rs1         = if_id.instr[19:15];
  assign rs2         = if_id.instr[24:20];
  assign f7          = if_id.instr[31:25];
  assign immediate   = if_id.imm;

endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: table-driven bench for if_id_stage.
// Each table row gives the inputs for one cycle and the outputs expected
// just after the following rising edge. A second instance with
// RESET_PC = 32'hFFFF_FFFC covers PC wrap-around.
module tb_if_id_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (RESET_PC = 0) ----------------
  logic        rst, stl, rdv, iv;
  logic [31:0] rdpc, rdata;
  logic        d1_req, d1_valid;
  logic [31:0] d1_addr, d1_pc, d1_imm;
  logic [6:0]  d1_op, d1_f7;
  logic [4:0]  d1_rd, d1_rs1, d1_rs2;
  logic [2:0]  d1_f3;

  if_id_stage dut (
    .clock          (clk),
    .reset          (rst),
    .stall          (stl),
    .redirect_valid (rdv),
    .redirect_pc    (rdpc),
    .imem_req       (d1_req),
    .imem_addr      (d1_addr),
    .imem_valid     (iv),
    .imem_rdata     (rdata),
    .instr_valid    (d1_valid),
    .pc_out         (d1_pc),
    .opcode         (d1_op),
    .rd             (d1_rd),
    .f3             (d1_f3),
    .rs1            (d1_rs1),
    .rs2            (d1_rs2),
    .f7             (d1_f7),
    .immediate      (d1_imm)
  );

  // ---------------- wrap DUT (RESET_PC = FFFF_FFFC) ----------------
  logic        r2, iv2;
  logic [31:0] rdata2;
  logic        zero_bit;
  logic [31:0] zero_word;
  logic        d2_req, d2_valid;
  logic [31:0] d2_addr, d2_pc, d2_imm;
  logic [6:0]  d2_op, d2_f7;
  logic [4:0]  d2_rd, d2_rs1, d2_rs2;
  logic [2:0]  d2_f3;

  if_id_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clock          (clk),
    .reset          (r2),
    .stall          (zero_bit),
    .redirect_valid (zero_bit),
    .redirect_pc    (zero_word),
    .imem_req       (d2_req),
    .imem_addr      (d2_addr),
    .imem_valid     (iv2),
    .imem_rdata     (rdata2),
    .instr_valid    (d2_valid),
    .pc_out         (d2_pc),
    .opcode         (d2_op),
    .rd             (d2_rd),
    .f3             (d2_f3),
    .rs1            (d2_rs1),
    .rs2            (d2_rs2),
    .f7             (d2_f7),
    .immediate      (d2_imm)
  );

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, stl, rdv;
    logic [31:0] rdpc;
    logic        iv;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
    logic [31:0] word;   // IF/ID fields reassembled as {f7,rs2,rs1,f3,rd,opcode}
    logic [31:0] imm;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic rv, input logic [31:0] rp,
                     input logic v_in, input logic [31:0] d,
                     input logic e_req, input logic [31:0] e_addr, input logic e_v,
                     input logic [31:0] e_pc, input logic [31:0] e_word, input logic [31:0] e_imm);
    vec_t t;
    t.rst = r; t.stl = s; t.rdv = rv; t.rdpc = rp; t.iv = v_in; t.rdata = d;
    t.req = e_req; t.addr = e_addr; t.v = e_v; t.pc = e_pc; t.word = e_word; t.imm = e_imm;
    vecs.push_back(t);
  endtask

  initial begin
    zero_bit = 1'b0; zero_word = '0;
    rst = 1'b1; stl = 1'b0; rdv = 1'b0; rdpc = '0; iv = 1'b1; rdata = 32'h0000_0013;
    r2 = 1'b1; iv2 = 1'b1; rdata2 = 32'h0000_0013;

    // ---- wrap-around sequence on the second instance ----
    repeat (2) @(posedge clk);
    #1;
    check("wrap reset req/addr", {31'b0, d2_req, d2_addr}, {31'b0, 1'b1, 32'hFFFF_FFFC});
    check("wrap reset valid",    {63'b0, d2_valid}, 64'd0);
    r2 = 1'b0;
    @(posedge clk); #1;
    check("wrap addr after fetch", {31'b0, d2_req, d2_addr}, {31'b0, 1'b1, 32'h0000_0000});
    check("wrap pc_out",           {31'b0, d2_valid, d2_pc}, {31'b0, 1'b1, 32'hFFFF_FFFC});

    // ---- main table ----
    //   rst  stl  rdv  rdpc        iv   rdata          req  addr        v    pc          word           imm
    add(1,   0,   0,   32'h0,      1,   32'h00000013,  1,   32'h0,      0,   32'h0,      32'h0,         32'h0);
    add(1,   0,   0,   32'h0,      1,   32'h00000013,  1,   32'h0,      0,   32'h0,      32'h0,         32'h0);
    // addi x1,x0,5 at 0
    add(0,   0,   0,   32'h0,      1,   32'h00500093,  1,   32'h4,      1,   32'h0,      32'h00500093,  32'h5);
    add(0,   0,   0,   32'h0,      1,   32'h00000013,  1,   32'h8,      1,   32'h4,      32'h00000013,  32'h0);
    // add x2,x1,x2 at 8 arrives under a 3-cycle stall
    add(0,   1,   0,   32'h0,      1,   32'h00208133,  0,   32'h8,      1,   32'h4,      32'h00000013,  32'h0);
    add(0,   1,   0,   32'h0,      0,   32'h0,         0,   32'h8,      1,   32'h4,      32'h00000013,  32'h0);
    add(0,   1,   0,   32'h0,      0,   32'h0,         0,   32'h8,      1,   32'h4,      32'h00000013,  32'h0);
    add(0,   0,   0,   32'h0,      0,   32'h0,         1,   32'hC,      1,   32'h8,      32'h00208133,  32'h0);
    // nothing accepted -> bubble, then held by a stall
    add(0,   0,   0,   32'h0,      0,   32'h0,         1,   32'hC,      0,   32'h0,      32'h0,         32'h0);
    add(0,   1,   0,   32'h0,      0,   32'h0,         1,   32'hC,      0,   32'h0,      32'h0,         32'h0);
    // beq x0,x0,-4 and sw x1,12(x2)
    add(0,   0,   0,   32'h0,      1,   32'hFE000EE3,  1,   32'h10,     1,   32'hC,      32'hFE000EE3,  32'hFFFFFFFC);
    add(0,   0,   0,   32'h0,      1,   32'h00112623,  1,   32'h14,     1,   32'h10,     32'h00112623,  32'hC);
    // redirect with request pending, stale word next cycle
    add(0,   0,   1,   32'h100,    0,   32'h0,         0,   32'h100,    0,   32'h0,      32'h0,         32'h0);
    add(0,   0,   0,   32'h0,      1,   32'h00500093,  1,   32'h100,    0,   32'h0,      32'h0,         32'h0);
    add(0,   0,   0,   32'h0,      1,   32'h00500093,  1,   32'h104,    1,   32'h100,    32'h00500093,  32'h5);
    // redirect coincident with a response
    add(0,   0,   1,   32'h20,     1,   32'h00208133,  1,   32'h20,     0,   32'h0,      32'h0,         32'h0);
    // word buffered under stall, then redirect discards the buffer
    add(0,   1,   0,   32'h0,      1,   32'h00500093,  0,   32'h20,     0,   32'h0,      32'h0,         32'h0);
    add(0,   1,   1,   32'h40,     0,   32'h0,         1,   32'h40,     0,   32'h0,      32'h0,         32'h0);
    add(0,   0,   0,   32'h0,      0,   32'h0,         1,   32'h40,     0,   32'h0,      32'h0,         32'h0);
    // jal x0,16 at 0x20
    add(0,   0,   1,   32'h20,     1,   32'h00000013,  1,   32'h20,     0,   32'h0,      32'h0,         32'h0);
    add(0,   0,   0,   32'h0,      1,   32'h0100006F,  1,   32'h24,     1,   32'h20,     32'h0100006F,  32'h10);
`ifdef IF_EARLY_JAL_EN
    add(0,   0,   0,   32'h0,      1,   32'h00000013,  1,   32'h30,     0,   32'h0,      32'h0,         32'h0);
    add(0,   0,   0,   32'h0,      1,   32'h00500093,  1,   32'h34,     1,   32'h30,     32'h00500093,  32'h5);
`else
    add(0,   0,   0,   32'h0,      1,   32'h00000013,  1,   32'h28,     1,   32'h24,     32'h00000013,  32'h0);
    add(0,   0,   0,   32'h0,      1,   32'h00500093,  1,   32'h2C,     1,   32'h28,     32'h00500093,  32'h5);
`endif
    // one-cycle reset while a request is outstanding; late response dropped
    add(1,   0,   0,   32'h0,      0,   32'h0,         0,   32'h0,      0,   32'h0,      32'h0,         32'h0);
    add(0,   0,   0,   32'h0,      1,   32'h00500093,  1,   32'h0,      0,   32'h0,      32'h0,         32'h0);
    add(0,   0,   0,   32'h0,      1,   32'h00500093,  1,   32'h4,      1,   32'h0,      32'h00500093,  32'h5);
    // lui x1,0x12345 and addi x1,x0,-1
    add(0,   0,   0,   32'h0,      1,   32'h123450B7,  1,   32'h8,      1,   32'h4,      32'h123450B7,  32'h12345000);
    add(0,   0,   0,   32'h0,      1,   32'hFFF00093,  1,   32'hC,      1,   32'h8,      32'hFFF00093,  32'hFFFFFFFF);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; stl = vecs[i].stl; rdv = vecs[i].rdv; rdpc = vecs[i].rdpc;
      iv = vecs[i].iv; rdata = vecs[i].rdata;
      @(posedge clk); #1;
      check($sformatf("row%0d req/addr", i), {31'b0, d1_req, d1_addr}, {31'b0, vecs[i].req, vecs[i].addr});
      check($sformatf("row%0d valid/pc", i), {31'b0, d1_valid, d1_pc}, {31'b0, vecs[i].v, vecs[i].pc});
      check($sformatf("row%0d fields", i),
            {32'b0, d1_f7, d1_rs2, d1_rs1, d1_f3, d1_rd, d1_op}, {32'b0, vecs[i].word});
      check($sformatf("row%0d immediate", i), {32'b0, d1_imm}, {32'b0, vecs[i].imm});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
